// File: rtl/reg_share_arbiter_pkg.sv
// Shared types, sizing and helper functions for the shared-register arbiter.
package reg_arb_pkg;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned IDW      = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // One-hot decode of a requester ID.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // First set request scanning upward from ptr, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDW-1:0]  ptr);
    logic        found;
    int unsigned idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[IDW'(idx)]) begin
        found   = 1'b1;
        rr_pick = IDW'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the shared register: requests, data and published state.
interface reg_share_arbiter_if;
  import reg_arb_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [IDW-1:0]        q_owner;
  logic                  q_upd;
  logic                  busy;

  modport master (
    output req, lock, wdata,
    input  gnt, q, q_owner, q_upd, busy
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, q_owner, q_upd, busy
  );
endinterface

// File: rtl/reg_share_arbiter_rr_picker.sv
// Rotating-priority encoder: first active request at or above ptr, with wrap.
module rr_picker
  import reg_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            valid_c_o,
  output logic [IDW-1:0]  index_c_o
);

  assign valid_c_o = |req_i;
  assign index_c_o = rr_pick(req_i, ptr_i);

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register among NREQ requesters.
module reg_share_arbiter
  import reg_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  reg_share_arbiter_if.slave  bus
);

  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IDW-1:0]   q_owner_q, q_owner_d;
  logic             q_upd_q, q_upd_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;

  logic             pick_valid_c;
  logic [IDW-1:0]   pick_idx_c;
  logic             wr_c;
  logic             release_c;

  rr_picker u_picker (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .valid_c_o (pick_valid_c),
    .index_c_o (pick_idx_c)
  );

  // Handshake and release decisions for the current owner.
  assign wr_c      = (state_q == OWNED) && bus.req[owner_q] && gnt_q[owner_q];
  assign release_c = (state_q == OWNED) &&
                     (!bus.lock[owner_q] ||
                      (hold_q == HCW'(MAX_HOLD - 1)) ||
                      (!bus.req[owner_q] && !bus.lock[owner_q]));

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      q_q       <= '0;
      q_owner_q <= '0;
      q_upd_q   <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      q_q       <= q_d;
      q_owner_q <= q_owner_d;
      q_upd_q   <= q_upd_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
    end
  end

  // Ownership sequencing: acquire in IDLE, count and release in OWNED.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          owner_d = pick_idx_c;
          hold_d  = '0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (hold_q != HCW'(MAX_HOLD)) hold_d = hold_q + HCW'(1);
        if (release_c) begin
          state_d = IDLE;
          ptr_d   = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the published outputs; gnt/busy follow the next state.
  always_comb begin
    q_d       = q_q;
    q_owner_d = q_owner_q;
    q_upd_d   = 1'b0;
    gnt_d     = '0;
    busy_d    = 1'b0;
    if (wr_c) begin
      q_d       = bus.wdata[owner_q*WIDTH +: WIDTH];
      q_owner_d = owner_q;
      q_upd_d   = 1'b1;
    end
    if (state_d == OWNED) begin
      gnt_d  = onehot(owner_d);
      busy_d = 1'b1;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.q       = q_q;
  assign bus.q_owner = q_owner_q;
  assign bus.q_upd   = q_upd_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter with a cycle-level ownership model.
module tb_reg_share_arbiter;
  import reg_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_share_arbiter_if bus();

  reg_share_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model: who owns the register, for how many cycles, and what was last written.
  bit         m_own;
  int         m_owner;
  int         m_held;
  int         m_ptr;
  logic [3:0] m_q;
  int         m_qown;
  bit         m_upd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_owner = 0; m_held = 0; m_ptr = 0;
    m_q = '0; m_qown = 0; m_upd = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int c;
    if (!rst_n) return;
    m_upd = 0;
    if (!m_own) begin
      if (bus.req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (bus.req[c]) begin
            m_owner = c;
            break;
          end
        end
        m_own  = 1;
        m_held = 0;
      end
    end else begin
      if (bus.req[m_owner]) begin
        m_upd  = 1;
        m_q    = bus.wdata[m_owner*WIDTH +: WIDTH];
        m_qown = m_owner;
      end
      m_held++;
      if (!bus.lock[m_owner] || m_held >= MAX_HOLD) begin
        m_own = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt",     32'(bus.gnt),     m_own ? (32'd1 << m_owner) : 32'd0);
      chk("busy",    32'(bus.busy),    32'(m_own));
      chk("q",       32'(bus.q),       32'(m_q));
      chk("q_owner", 32'(bus.q_owner), 32'(m_qown));
      chk("q_upd",   32'(bus.q_upd),   32'(m_upd));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.req = '0; bus.lock = '0; bus.wdata = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ng;
    int nu;
    bus.req = '0; bus.lock = '0; bus.wdata = '0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst_gnt",  32'(bus.gnt),  32'h0);
    chk("rst_q",    32'(bus.q),    32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_upd",  32'(bus.q_upd), 32'h0);
    rst_n = 1'b1;

    // Single writer.
    bus.req = 4'b0001; bus.wdata[3:0] = 4'hA;
    step();
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    step();
    chk("t1_q", 32'(bus.q), 32'hA);
    chk("t1_owner", 32'(bus.q_owner), 32'h0);
    chk("t1_upd", 32'(bus.q_upd), 32'h1);
    chk("t1_gnt_rel", 32'(bus.gnt), 32'h0);
    bus.req = '0;
    step(2);
    chk("t1_q_hold", 32'(bus.q), 32'hA);
    chk("t1_upd_low", 32'(bus.q_upd), 32'h0);

    // Round-robin rotation with all requesting.
    do_reset();
    bus.req = 4'b1111; bus.wdata = 16'h4321;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k % 2 == 0) begin
        chk("t2_q", 32'(bus.q), 32'(((k / 2 - 1) % 4) + 1));
        chk("t2_owner", 32'(bus.q_owner), 32'((k / 2 - 1) % 4));
        chk("t2_upd", 32'(bus.q_upd), 32'h1);
      end else begin
        chk("t2_upd_gap", 32'(bus.q_upd), 32'h0);
      end
    end

    // Locked burst by requester 1, then hand-off to requester 2.
    do_reset();
    bus.req = 4'b0010; bus.lock = 4'b0010; bus.wdata[7:4] = 4'h5;
    step();
    chk("t3_gnt", 32'(bus.gnt), 32'h2);
    for (int v = 5; v <= 7; v++) begin
      bus.wdata[7:4] = 4'(v);
      step();
      chk("t3_q", 32'(bus.q), 32'(v));
      chk("t3_upd", 32'(bus.q_upd), 32'h1);
      chk("t3_gnt_hold", 32'(bus.gnt), 32'h2);
      chk("t3_busy", 32'(bus.busy), 32'h1);
    end
    bus.lock = '0; bus.req = 4'b0110; bus.wdata[7:4] = 4'h8;
    step();
    chk("t3_last_q", 32'(bus.q), 32'h8);
    chk("t3_rel_gnt", 32'(bus.gnt), 32'h0);
    step();
    chk("t3_next_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    step();

    // Hold timeout: requester 3 locks without writing.
    do_reset();
    bus.req = 4'b1000; bus.lock = 4'b1000;
    step();
    chk("t4_gnt", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0001;
    ng = 1; nu = 0;
    repeat (8) begin
      step();
      if (bus.gnt == 4'b1000) ng++;
      if (bus.q_upd) nu++;
    end
    chk("t4_hold_cycles", 32'(ng), 32'd8);
    chk("t4_no_upd", 32'(nu), 32'd0);
    chk("t4_idle", 32'(bus.gnt), 32'h0);
    step();
    chk("t4_next_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0; bus.lock = '0;
    step();

    // Asynchronous reset in the middle of a handshake cycle.
    do_reset();
    bus.req = 4'b0100; bus.lock = 4'b0100; bus.wdata[11:8] = 4'hF;
    step();
    chk("t5_gnt", 32'(bus.gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_q_now", 32'(bus.q), 32'h0);
    chk("t5_gnt_now", 32'(bus.gnt), 32'h0);
    chk("t5_busy_now", 32'(bus.busy), 32'h0);
    step();
    chk("t5_q_in_rst", 32'(bus.q), 32'h0);
    do_reset();
    step();
    chk("t5_q_after", 32'(bus.q), 32'h0);

    // Owner abandons without writing.
    do_reset();
    bus.req = 4'b0001;
    step();
    chk("t6_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0010; bus.lock = '0;
    step();
    chk("t6_rel_gnt", 32'(bus.gnt), 32'h0);
    chk("t6_no_upd", 32'(bus.q_upd), 32'h0);
    step();
    chk("t6_next_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    step(2);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
